io_word_buffer: RTL and testbench

- Buffers host I/O between the UART byte interface and the pipeline's ININT/INFLT/OUT instructions.
- Input side: assembles incoming UART bytes into 32-bit words and queues them in a word FIFO.
- Output side: queues bytes from OUT instructions in a byte FIFO and drains them to the UART transmitter.
- Drives in_busy/out_busy straight into the stall controller. This block is the direct upstream producer of those two signals.

---
 rtl/io_word_buffer.sv | 172 +++++++++++++++++
 tb/tb_io_word_buffer.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/io_word_buffer.sv
// io_word_buffer
//   Host I/O buffering between the UART byte interface and the pipeline's
//   ININT/INFLT/OUT instructions.
//   Input side : received bytes are assembled big-endian into 32-bit words
//                and queued in a word FIFO read by ININT/INFLT at commit.
//   Output side: bytes written by OUT at commit are queued in a byte FIFO
//                and drained to the UART transmitter with a valid/ready pair.
//
// Ports
//   clk, rst     : clock (rising edge), synchronous active-high reset
//   rx_valid     : one-cycle strobe, rx_data holds a received byte
//   rx_data      : received byte
//   in_pop       : pipeline consumes the head word
//   in_word      : head word of input FIFO, 0 when empty
//   in_busy      : input FIFO empty (stall ININT/INFLT)
//   out_push     : pipeline writes out_byte
//   out_byte     : byte to transmit
//   out_busy     : output FIFO full (stall OUT)
//   tx_valid     : output FIFO non-empty
//   tx_data      : head byte of output FIFO, 0 when empty
//   tx_ready     : transmitter accepts tx_data this cycle
//   rx_overflow  : sticky, a completed word was dropped on a full input FIFO
//   tx_overflow  : sticky, out_push arrived while output FIFO was full
module io_word_buffer #(
  parameter int IN_DEPTH_LOG2  = 4,
  parameter int OUT_DEPTH_LOG2 = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rx_valid,
  input  logic [7:0]  rx_data,
  input  logic        in_pop,
  output logic [31:0] in_word,
  output logic        in_busy,
  input  logic        out_push,
  input  logic [7:0]  out_byte,
  output logic        out_busy,
  output logic        tx_valid,
  output logic [7:0]  tx_data,
  input  logic        tx_ready,
  output logic        rx_overflow,
  output logic        tx_overflow
);

  localparam int IN_DEPTH  = 1 << IN_DEPTH_LOG2;
  localparam int OUT_DEPTH = 1 << OUT_DEPTH_LOG2;

  localparam logic [IN_DEPTH_LOG2:0]  IN_PTR_ONE  = {{IN_DEPTH_LOG2{1'b0}}, 1'b1};
  localparam logic [OUT_DEPTH_LOG2:0] OUT_PTR_ONE = {{OUT_DEPTH_LOG2{1'b0}}, 1'b1};

  // ---------------------------------------------------------------------
  // Input side state
  // ---------------------------------------------------------------------
  logic [31:0]              in_mem [IN_DEPTH];
  logic [IN_DEPTH_LOG2:0]   in_wptr;
  logic [IN_DEPTH_LOG2:0]   in_rptr;
  logic [1:0]               bcnt;
  logic [23:0]              shreg;

  logic                     in_empty;
  logic                     in_full;
  logic                     word_done;
  logic                     in_pop_ok;
  logic                     in_push_ok;
  logic                     in_drop;
  logic [31:0]              word_new;

  assign in_empty  = (in_wptr == in_rptr);
  // Extra pointer MSB differs only when the writer is a full lap ahead.
  assign in_full   = (in_wptr[IN_DEPTH_LOG2] != in_rptr[IN_DEPTH_LOG2]) &&
                     (in_wptr[IN_DEPTH_LOG2-1:0] == in_rptr[IN_DEPTH_LOG2-1:0]);
  assign word_done = rx_valid && (bcnt == 2'd3);
  assign word_new  = {shreg, rx_data};
  assign in_pop_ok = in_pop && !in_empty;
  // A pop on the same edge frees the slot, so a full FIFO can still accept.
  assign in_push_ok = word_done && (!in_full || in_pop_ok);
  assign in_drop    = word_done && in_full && !in_pop_ok;

  assign in_busy = in_empty;
  assign in_word = in_empty ? 32'h0 : in_mem[in_rptr[IN_DEPTH_LOG2-1:0]];

  // ---------------------------------------------------------------------
  // Input assembly and word FIFO control
  // ---------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      bcnt        <= 2'd0;
      shreg       <= 24'h0;
      in_wptr     <= '0;
      in_rptr     <= '0;
      rx_overflow <= 1'b0;
    end else begin
      if (rx_valid) begin
        if (bcnt == 2'd3) begin
          bcnt <= 2'd0;
        end else begin
          shreg <= {shreg[15:0], rx_data};
          bcnt  <= bcnt + 2'd1;
        end
      end
      if (in_push_ok) begin
        in_wptr <= in_wptr + IN_PTR_ONE;
      end
      if (in_pop_ok) begin
        in_rptr <= in_rptr + IN_PTR_ONE;
      end
      if (in_drop) begin
        rx_overflow <= 1'b1;
      end
    end
  end

  // Storage carries no reset; validity is tracked by the pointers alone.
  always_ff @(posedge clk) begin
    if (!rst && in_push_ok) begin
      in_mem[in_wptr[IN_DEPTH_LOG2-1:0]] <= word_new;
    end
  end

  // ---------------------------------------------------------------------
  // Output side state
  // ---------------------------------------------------------------------
  logic [7:0]               out_mem [OUT_DEPTH];
  logic [OUT_DEPTH_LOG2:0]  out_wptr;
  logic [OUT_DEPTH_LOG2:0]  out_rptr;

  logic                     out_empty;
  logic                     out_full;
  logic                     tx_pop;
  logic                     out_push_ok;
  logic                     out_drop;

  assign out_empty   = (out_wptr == out_rptr);
  assign out_full    = (out_wptr[OUT_DEPTH_LOG2] != out_rptr[OUT_DEPTH_LOG2]) &&
                       (out_wptr[OUT_DEPTH_LOG2-1:0] == out_rptr[OUT_DEPTH_LOG2-1:0]);
  assign tx_pop      = !out_empty && tx_ready;
  assign out_push_ok = out_push && (!out_full || tx_pop);
  assign out_drop    = out_push && out_full && !tx_pop;

  assign out_busy = out_full;
  assign tx_valid = !out_empty;
  // Head only moves on a pop, so tx_data is stable while stalled.
  assign tx_data  = out_empty ? 8'h0 : out_mem[out_rptr[OUT_DEPTH_LOG2-1:0]];

  // ---------------------------------------------------------------------
  // Output byte FIFO control
  // ---------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      out_wptr    <= '0;
      out_rptr    <= '0;
      tx_overflow <= 1'b0;
    end else begin
      if (out_push_ok) begin
        out_wptr <= out_wptr + OUT_PTR_ONE;
      end
      if (tx_pop) begin
        out_rptr <= out_rptr + OUT_PTR_ONE;
      end
      if (out_drop) begin
        tx_overflow <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && out_push_ok) begin
      out_mem[out_wptr[OUT_DEPTH_LOG2-1:0]] <= out_byte;
    end
  end

endmodule

// File: tb/tb_io_word_buffer.sv
module tb_io_word_buffer;

  logic        clk = 1'b0;
  logic        rst;
  logic        rx_valid;
  logic [7:0]  rx_data;
  logic        in_pop;
  logic [31:0] in_word;
  logic        in_busy;
  logic        out_push;
  logic [7:0]  out_byte;
  logic        out_busy;
  logic        tx_valid;
  logic [7:0]  tx_data;
  logic        tx_ready;
  logic        rx_overflow;
  logic        tx_overflow;

  int n_cmp = 0;
  int n_err = 0;

  io_word_buffer #(.IN_DEPTH_LOG2(4), .OUT_DEPTH_LOG2(4)) dut (
    .clk(clk), .rst(rst),
    .rx_valid(rx_valid), .rx_data(rx_data),
    .in_pop(in_pop), .in_word(in_word), .in_busy(in_busy),
    .out_push(out_push), .out_byte(out_byte), .out_busy(out_busy),
    .tx_valid(tx_valid), .tx_data(tx_data), .tx_ready(tx_ready),
    .rx_overflow(rx_overflow), .tx_overflow(tx_overflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rxv;
    logic [7:0]  rxd;
    logic        pop;
    logic        push;
    logic [7:0]  ob;
    logic        rdy;
    logic        e_in_busy;
    logic [31:0] e_word;
    logic        e_out_busy;
    logic        e_txv;
    logic [7:0]  e_txd;
  } vec_t;

  localparam int NVEC = 22;
  vec_t vecs [NVEC];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    rx_valid = 1'b0; rx_data = 8'h00; in_pop = 1'b0;
    out_push = 1'b0; out_byte = 8'h00; tx_ready = 1'b0;
  endtask

  // Inputs are changed 1 time unit after a rising edge; outputs are sampled there too.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    idle_inputs();
    rx_valid = 1'b1; rx_data = b;
    tick();
    idle_inputs();
  endtask

  function automatic logic [31:0] fill_word(input int i);
    logic [7:0] b0, b1, b2, b3;
    b0 = 8'(4 * i);
    b1 = 8'(4 * i + 1);
    b2 = 8'(4 * i + 2);
    b3 = 8'(4 * i + 3);
    return {b0, b1, b2, b3};
  endfunction

  initial begin
    // rxv rxd pop push ob rdy | in_busy word out_busy txv txd
    vecs[0]  = '{1'b1, 8'h12, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 32'h0,        1'b0, 1'b0, 8'h00};
    vecs[1]  = '{1'b1, 8'h34, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 32'h0,        1'b0, 1'b0, 8'h00};
    vecs[2]  = '{1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 32'h0,        1'b0, 1'b0, 8'h00};
    vecs[3]  = '{1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 32'h0,        1'b0, 1'b0, 8'h00};
    vecs[4]  = '{1'b1, 8'h56, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 32'h0,        1'b0, 1'b0, 8'h00};
    vecs[5]  = '{1'b1, 8'h78, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 32'h12345678, 1'b0, 1'b0, 8'h00};
    vecs[6]  = '{1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 32'h12345678, 1'b0, 1'b0, 8'h00};
    vecs[7]  = '{1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 32'h0,        1'b0, 1'b0, 8'h00};
    vecs[8]  = '{1'b0, 8'h00, 1'b0, 1'b1, 8'h41, 1'b0, 1'b1, 32'h0,        1'b0, 1'b1, 8'h41};
    vecs[9]  = '{1'b0, 8'h00, 1'b0, 1'b1, 8'h42, 1'b0, 1'b1, 32'h0,        1'b0, 1'b1, 8'h41};
    vecs[10] = '{1'b0, 8'h00, 1'b0, 1'b1, 8'h43, 1'b0, 1'b1, 32'h0,        1'b0, 1'b1, 8'h41};
    vecs[11] = '{1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 32'h0,        1'b0, 1'b1, 8'h41};
    vecs[12] = '{1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 32'h0,        1'b0, 1'b1, 8'h42};
    vecs[13] = '{1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 32'h0,        1'b0, 1'b1, 8'h43};
    vecs[14] = '{1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 32'h0,        1'b0, 1'b0, 8'h00};
    vecs[15] = '{1'b1, 8'h01, 1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 32'h0,        1'b0, 1'b0, 8'h00};
    vecs[16] = '{1'b1, 8'h02, 1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 32'h0,        1'b0, 1'b0, 8'h00};
    vecs[17] = '{1'b1, 8'h03, 1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 32'h0,        1'b0, 1'b0, 8'h00};
    vecs[18] = '{1'b1, 8'h04, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 32'h01020304, 1'b0, 1'b0, 8'h00};
    vecs[19] = '{1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 32'h0,        1'b0, 1'b0, 8'h00};
    vecs[20] = '{1'b0, 8'h00, 1'b0, 1'b1, 8'h55, 1'b1, 1'b1, 32'h0,        1'b0, 1'b1, 8'h55};
    vecs[21] = '{1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 32'h0,        1'b0, 1'b0, 8'h00};

    idle_inputs();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;

    // Reset state
    chk("rst_in_busy",  32'(in_busy),     32'd1);
    chk("rst_in_word",  in_word,          32'h0);
    chk("rst_out_busy", 32'(out_busy),    32'd0);
    chk("rst_tx_valid", 32'(tx_valid),    32'd0);
    chk("rst_tx_data",  32'(tx_data),     32'h0);
    chk("rst_rx_ovf",   32'(rx_overflow), 32'd0);
    chk("rst_tx_ovf",   32'(tx_overflow), 32'd0);

    // Table-driven vectors
    for (int v = 0; v < NVEC; v++) begin
      rx_valid = vecs[v].rxv; rx_data = vecs[v].rxd; in_pop = vecs[v].pop;
      out_push = vecs[v].push; out_byte = vecs[v].ob; tx_ready = vecs[v].rdy;
      tick();
      chk($sformatf("vec%0d_in_busy", v),  32'(in_busy),  32'(vecs[v].e_in_busy));
      chk($sformatf("vec%0d_in_word", v),  in_word,       vecs[v].e_word);
      chk($sformatf("vec%0d_out_busy", v), 32'(out_busy), 32'(vecs[v].e_out_busy));
      chk($sformatf("vec%0d_tx_valid", v), 32'(tx_valid), 32'(vecs[v].e_txv));
      chk($sformatf("vec%0d_tx_data", v),  32'(tx_data),  32'(vecs[v].e_txd));
    end
    idle_inputs();
    chk("vec_rx_ovf", 32'(rx_overflow), 32'd0);
    chk("vec_tx_ovf", 32'(tx_overflow), 32'd0);

    // Input FIFO fill and overflow
    do_reset();
    for (int i = 0; i < 16; i++) begin
      for (int j = 0; j < 4; j++) send_byte(8'(4 * i + j));
    end
    chk("fill_in_busy", 32'(in_busy), 32'd0);
    chk("fill_rx_ovf",  32'(rx_overflow), 32'd0);
    chk("fill_head",    in_word, fill_word(0));
    for (int j = 0; j < 4; j++) send_byte(8'(64 + j));
    chk("ovf_rx_ovf",   32'(rx_overflow), 32'd1);
    for (int i = 0; i < 16; i++) begin
      chk($sformatf("drain_word%0d", i), in_word, fill_word(i));
      chk($sformatf("drain_busy%0d", i), 32'(in_busy), 32'd0);
      in_pop = 1'b1;
      tick();
      in_pop = 1'b0;
    end
    chk("drain_in_busy", 32'(in_busy), 32'd1);
    chk("drain_in_word", in_word, 32'h0);
    chk("drain_rx_ovf_sticky", 32'(rx_overflow), 32'd1);

    // Reset discards a partial word
    do_reset();
    send_byte(8'h11);
    send_byte(8'h22);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("partrst_rx_ovf", 32'(rx_overflow), 32'd0);
    send_byte(8'hAA);
    send_byte(8'hBB);
    send_byte(8'hCC);
    chk("partrst_busy_pre", 32'(in_busy), 32'd1);
    send_byte(8'hDD);
    chk("partrst_busy", 32'(in_busy), 32'd0);
    chk("partrst_word", in_word, 32'hAABBCCDD);

    // Output FIFO fill, overflow, push+pop while full
    do_reset();
    for (int i = 0; i < 16; i++) begin
      out_push = 1'b1; out_byte = 8'(8'h10 + i); tx_ready = 1'b0;
      tick();
      chk($sformatf("ofill_busy%0d", i), 32'(out_busy), (i == 15) ? 32'd1 : 32'd0);
    end
    idle_inputs();
    chk("ofill_tx_data", 32'(tx_data), 32'h10);
    chk("ofill_tx_ovf",  32'(tx_overflow), 32'd0);
    out_push = 1'b1; out_byte = 8'hFF; tx_ready = 1'b0;
    tick();
    idle_inputs();
    chk("oovf_tx_ovf",   32'(tx_overflow), 32'd1);
    chk("oovf_busy",     32'(out_busy), 32'd1);
    chk("oovf_tx_data",  32'(tx_data), 32'h10);
    out_push = 1'b1; out_byte = 8'hEE; tx_ready = 1'b1;
    tick();
    idle_inputs();
    chk("opp_busy",      32'(out_busy), 32'd1);
    chk("opp_tx_data",   32'(tx_data), 32'h11);
    for (int i = 1; i < 17; i++) begin
      chk($sformatf("odrain%0d", i), 32'(tx_data), (i == 16) ? 32'hEE : 32'(8'h10 + i));
      tx_ready = 1'b1;
      tick();
      tx_ready = 1'b0;
    end
    chk("odrain_valid", 32'(tx_valid), 32'd0);
    chk("odrain_data",  32'(tx_data), 32'h0);

    // Wrap-around on both FIFOs
    do_reset();
    for (int k = 0; k < 40; k++) begin
      logic [7:0] b0, b1, b2, b3, ob;
      b0 = 8'(k); b1 = 8'(k + 100); b2 = 8'(k * 3); b3 = 8'(255 - k); ob = 8'(k + 7);
      idle_inputs();
      rx_valid = 1'b1; rx_data = b0; out_push = 1'b1; out_byte = ob;
      tick();
      chk($sformatf("wrap%0d_txv", k),  32'(tx_valid), 32'd1);
      chk($sformatf("wrap%0d_txd", k),  32'(tx_data), 32'(ob));
      chk($sformatf("wrap%0d_obusy", k), 32'(out_busy), 32'd0);
      idle_inputs();
      rx_valid = 1'b1; rx_data = b1; tx_ready = 1'b1;
      tick();
      chk($sformatf("wrap%0d_txv0", k), 32'(tx_valid), 32'd0);
      send_byte(b2);
      send_byte(b3);
      chk($sformatf("wrap%0d_ibusy", k), 32'(in_busy), 32'd0);
      chk($sformatf("wrap%0d_word", k),  in_word, {b0, b1, b2, b3});
      in_pop = 1'b1;
      tick();
      in_pop = 1'b0;
      chk($sformatf("wrap%0d_empty", k), 32'(in_busy), 32'd1);
    end
    chk("wrap_rx_ovf", 32'(rx_overflow), 32'd0);
    chk("wrap_tx_ovf", 32'(tx_overflow), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
